// File: rtl/line_mem_pkg.sv
// Shared types for the line memory responder: FSM state encoding, latency
// counter width and a saturating increment used by the optional statistics.
package line_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   // Wide enough for LATENCY-1 at the maximum legal latency of 255.
   localparam int CNT_W = 8;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/line_mem_array.sv
// Line-wide storage: one synchronous write port, one asynchronous read port.
// Contents are not touched by reset.
module line_mem_array #(
   parameter int LINE_ADDR_LEN = 3,
   parameter int ADDR_LEN      = 9
) (
   input  logic                                 clk,
   input  logic                                 we,
   input  logic [ADDR_LEN-1:0]                  waddr,
   input  logic [(1<<LINE_ADDR_LEN)-1:0][31:0]  wdata,
   input  logic [ADDR_LEN-1:0]                  raddr,
   output logic [(1<<LINE_ADDR_LEN)-1:0][31:0]  rdata
);

   localparam int WORDS = 1 << LINE_ADDR_LEN;
   localparam int DEPTH = 1 << ADDR_LEN;

   logic [WORDS-1:0][31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/line_mem_resp.sv
// Fixed-latency line read/write responder with IDLE/BUSY/DONE handshake.
// Optional build macro LINE_MEM_STATS_EN adds saturating rd_cnt/wr_cnt outputs.
module line_mem_resp
   import line_mem_pkg::*;
#(
   parameter int LINE_ADDR_LEN = 3,
   parameter int ADDR_LEN      = 9,
   parameter int LATENCY       = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [ADDR_LEN-1:0]                  addr,
   input  logic                                 rd_req,
   input  logic                                 wr_req,
   input  logic [(1<<LINE_ADDR_LEN)-1:0][31:0]  wr_line,
   output logic [(1<<LINE_ADDR_LEN)-1:0][31:0]  rd_line,
   output logic                                 gnt
`ifdef LINE_MEM_STATS_EN
   ,
   output logic [31:0]                          rd_cnt,
   output logic [31:0]                          wr_cnt
`endif
);

   localparam int               WORDS    = 1 << LINE_ADDR_LEN;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [ADDR_LEN-1:0]    addr_q;
   logic                   wr_op_q;
   logic [WORDS-1:0][31:0] wr_line_q;
   logic [WORDS-1:0][31:0] rd_line_q;
   logic                   gnt_q;

   logic                   accept;
   logic                   req_held;
   logic                   enter_done;
   logic                   op_wr_s;
   logic [ADDR_LEN-1:0]    addr_s;
   logic [WORDS-1:0][31:0] line_s;
   logic                   mem_we;
   logic                   rd_load;
   logic [WORDS-1:0][31:0] mem_rdata;

   assign accept   = (state_q == IDLE) && (rd_req || wr_req);
   // Abort watches only the request of the operation actually being serviced.
   assign req_held = wr_op_q ? wr_req : rd_req;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (rd_req || wr_req) begin
               state_d = (LATENCY == 1) ? DONE : BUSY;
            end
         end
         BUSY: begin
            if (!req_held) begin
               state_d = IDLE;
            end else if (cnt_q <= CNT_W'(1)) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // With LATENCY=1 the DONE edge is also the accept edge, so use live inputs.
   always_comb begin
      op_wr_s    = accept ? wr_req  : wr_op_q;
      addr_s     = accept ? addr    : addr_q;
      line_s     = accept ? wr_line : wr_line_q;
      enter_done = (state_d == DONE) && (state_q != DONE);
      mem_we     = enter_done && op_wr_s;
      rd_load    = enter_done && !op_wr_s;
      cnt_d      = cnt_q;
      if (accept) begin
         cnt_d = CNT_LOAD;
      end else if (state_q == BUSY) begin
         cnt_d = req_held ? cnt_q - CNT_W'(1) : '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         addr_q    <= '0;
         wr_op_q   <= 1'b0;
         wr_line_q <= '0;
         rd_line_q <= '0;
         gnt_q     <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         gnt_q <= (state_d == DONE);
         if (accept) begin
            addr_q    <= addr;
            wr_op_q   <= wr_req;
            wr_line_q <= wr_line;
         end
         if (rd_load) begin
            rd_line_q <= mem_rdata;
         end
      end
   end

   line_mem_array #(
      .LINE_ADDR_LEN (LINE_ADDR_LEN),
      .ADDR_LEN      (ADDR_LEN)
   ) u_array (
      .clk   (clk),
      .we    (mem_we),
      .waddr (addr_s),
      .wdata (line_s),
      .raddr (addr_s),
      .rdata (mem_rdata)
   );

   assign rd_line = rd_line_q;
   assign gnt     = gnt_q;

`ifdef LINE_MEM_STATS_EN
   logic [31:0] rd_cnt_q, wr_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
      end else begin
         if (rd_load) rd_cnt_q <= sat_inc(rd_cnt_q);
         if (mem_we)  wr_cnt_q <= sat_inc(wr_cnt_q);
      end
   end

   assign rd_cnt = rd_cnt_q;
   assign wr_cnt = wr_cnt_q;
`endif

endmodule

// File: tb/tb_line_mem_resp.sv
// Self-checking bench for line_mem_resp: directed scenarios plus randomized
// operations against a line-level storage model (stats checks when built with
// LINE_MEM_STATS_EN).
module tb_line_mem_resp;

   localparam int LAT = 4;
   localparam int LA  = 3;
   localparam int AL  = 9;
   localparam int W   = 1 << LA;

   typedef logic [W-1:0][31:0] line_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [AL-1:0] addr;
   logic          rd_req, wr_req;
   line_t         wr_line, rd_line;
   logic          gnt;
`ifdef LINE_MEM_STATS_EN
   logic [31:0]   rd_cnt, wr_cnt;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   line_t mem_m [int];
   line_t rd_line_m;

   always #5 clk = ~clk;

   line_mem_resp #(
      .LINE_ADDR_LEN (LA),
      .ADDR_LEN      (AL),
      .LATENCY       (LAT)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .addr    (addr),
      .rd_req  (rd_req),
      .wr_req  (wr_req),
      .wr_line (wr_line),
      .rd_line (rd_line),
      .gnt     (gnt)
`ifdef LINE_MEM_STATS_EN
      ,
      .rd_cnt  (rd_cnt),
      .wr_cnt  (wr_cnt)
`endif
   );

   function automatic line_t rand_line();
      line_t l;
      for (int i = 0; i < W; i++) l[i] = $urandom;
      return l;
   endfunction

   function automatic line_t model_rd(input int a);
      if (mem_m.exists(a)) return mem_m[a];
      return '0;
   endfunction

   // Requester: raises the request in cycle 0, scrambles addr/data afterwards,
   // drops the request in drop_cyc or in the cycle after gnt. Always bounded.
   task automatic run_req(input logic rd, input logic wr, input logic [AL-1:0] a,
                          input line_t l, input int drop_cyc,
                          output int gnt_cyc, output int gnt_n);
      gnt_cyc = -1;
      gnt_n   = 0;
      rd_req  = rd;
      wr_req  = wr;
      addr    = a;
      wr_line = l;
      for (int c = 0; c <= LAT + 3; c++) begin
         @(negedge clk);
         if (gnt === 1'b1) begin
            gnt_n++;
            if (gnt_cyc < 0) gnt_cyc = c;
         end
         @(posedge clk);
         #1;
         addr    = AL'($urandom);
         wr_line = rand_line();
         if (gnt_cyc >= 0 || c + 1 == drop_cyc) begin
            rd_req = 1'b0;
            wr_req = 1'b0;
         end
      end
      rd_req = 1'b0;
      wr_req = 1'b0;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      rd_line_m = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0; addr = '0; wr_line = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_chk++;
      if (gnt !== 1'b0) begin
         n_fail++; $display("FAIL reset_gnt: got %b expected 0", gnt);
      end
      n_chk++;
      if (rd_line !== '0) begin
         n_fail++; $display("FAIL reset_rd_line: got %h expected 0", rd_line);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      rd_line_m = '0;
   endtask

   task automatic test_write_read();
      line_t l;
      int gc, gn;
      for (int i = 0; i < W; i++) l[i] = 32'h100 + i;
      run_req(1'b0, 1'b1, 9'h005, l, -1, gc, gn);
      mem_m[5] = l;
      n_chk++;
      if (gc !== LAT || gn !== 1) begin
         n_fail++; $display("FAIL wr005_gnt: cycle %0d count %0d expected cycle %0d count 1", gc, gn, LAT);
      end
      run_req(1'b1, 1'b0, 9'h005, rand_line(), -1, gc, gn);
      rd_line_m = model_rd(5);
      n_chk++;
      if (gc !== LAT || gn !== 1) begin
         n_fail++; $display("FAIL rd005_gnt: cycle %0d count %0d expected cycle %0d count 1", gc, gn, LAT);
      end
      n_chk++;
      if (rd_line !== l) begin
         n_fail++; $display("FAIL rd005_data: got %h expected %h", rd_line, l);
      end
   endtask

   task automatic test_back_to_back();
      line_t l;
      int g1, g2;
      l = rand_line();
      g1 = -1; g2 = -1;
      rd_req = 1'b0; wr_req = 1'b1; addr = 9'h0A3; wr_line = l;
      for (int c = 0; c <= 3 * LAT; c++) begin
         @(negedge clk);
         if (gnt === 1'b1) begin
            if (g1 < 0) g1 = c;
            else if (g2 < 0) g2 = c;
         end
         @(posedge clk);
         #1;
         wr_line = rand_line();
         if (g1 >= 0 && c == g1) begin
            wr_req = 1'b0; rd_req = 1'b1; addr = 9'h0A3;
         end
         if (g2 >= 0 && c == g2) rd_req = 1'b0;
      end
      rd_req = 1'b0; wr_req = 1'b0;
      mem_m[9'h0A3] = l;
      rd_line_m = l;
      n_chk++;
      if (g1 !== LAT) begin
         n_fail++; $display("FAIL b2b_first_gnt: cycle %0d expected %0d", g1, LAT);
      end
      n_chk++;
      if (g2 - g1 !== LAT + 1) begin
         n_fail++; $display("FAIL b2b_gap: got %0d expected %0d", g2 - g1, LAT + 1);
      end
      n_chk++;
      if (rd_line !== rd_line_m) begin
         n_fail++; $display("FAIL b2b_data: got %h expected %h", rd_line, rd_line_m);
      end
   endtask

   task automatic test_abort();
      int gc, gn;
      run_req(1'b1, 1'b0, 9'h005, rand_line(), 2, gc, gn);
      n_chk++;
      if (gn !== 0) begin
         n_fail++; $display("FAIL abort_gnt: got %0d pulses expected 0", gn);
      end
      n_chk++;
      if (rd_line !== rd_line_m) begin
         n_fail++; $display("FAIL abort_rd_line: got %h expected %h", rd_line, rd_line_m);
      end
      run_req(1'b1, 1'b0, 9'h005, rand_line(), -1, gc, gn);
      rd_line_m = model_rd(5);
      n_chk++;
      if (gc !== LAT || gn !== 1 || rd_line !== rd_line_m) begin
         n_fail++; $display("FAIL abort_next: cycle %0d count %0d data %h expected cycle %0d data %h",
                            gc, gn, rd_line, LAT, rd_line_m);
      end
   endtask

   task automatic test_both();
      line_t l;
      int gc, gn;
      l = rand_line();
      run_req(1'b1, 1'b1, 9'h010, l, -1, gc, gn);
      mem_m[9'h010] = l;
      n_chk++;
      if (gc !== LAT || gn !== 1) begin
         n_fail++; $display("FAIL both_gnt: cycle %0d count %0d expected cycle %0d count 1", gc, gn, LAT);
      end
      n_chk++;
      if (rd_line !== rd_line_m) begin
         n_fail++; $display("FAIL both_rd_line: got %h expected %h", rd_line, rd_line_m);
      end
      run_req(1'b1, 1'b0, 9'h010, rand_line(), -1, gc, gn);
      rd_line_m = model_rd(9'h010);
      n_chk++;
      if (rd_line !== l) begin
         n_fail++; $display("FAIL both_storage: got %h expected %h", rd_line, l);
      end
   endtask

   task automatic test_reset_mid_busy();
      line_t la, lb;
      int gc, gn;
      la = rand_line();
      lb = rand_line();
      run_req(1'b0, 1'b1, 9'h1FF, la, -1, gc, gn);
      mem_m[9'h1FF] = la;
      rd_req = 1'b0; wr_req = 1'b1; addr = 9'h1FF; wr_line = lb;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      #1;
      n_chk++;
      if (gnt !== 1'b0 || rd_line !== '0) begin
         n_fail++; $display("FAIL rst_busy_immediate: gnt %b rd_line %h expected 0 and 0", gnt, rd_line);
      end
      wr_req = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      rd_line_m = '0;
      gn = 0;
      for (int c = 0; c < LAT + 2; c++) begin
         @(negedge clk);
         if (gnt === 1'b1) gn++;
      end
      n_chk++;
      if (gn !== 0) begin
         n_fail++; $display("FAIL rst_busy_gnt: got %0d pulses expected 0", gn);
      end
      @(posedge clk);
      #1;
      run_req(1'b1, 1'b0, 9'h1FF, rand_line(), -1, gc, gn);
      rd_line_m = model_rd(9'h1FF);
      n_chk++;
      if (rd_line !== la) begin
         n_fail++; $display("FAIL rst_busy_storage: got %h expected %h", rd_line, la);
      end
   endtask

   task automatic test_random();
      logic [AL-1:0] pool [8];
      int gc, gn, kind, drop;
      logic rd, wr;
      logic [AL-1:0] a;
      line_t l;
      for (int i = 0; i < 8; i++) begin
         pool[i] = AL'($urandom);
         l = rand_line();
         run_req(1'b0, 1'b1, pool[i], l, -1, gc, gn);
         mem_m[int'(pool[i])] = l;
         n_chk++;
         if (gc !== LAT || gn !== 1) begin
            n_fail++; $display("FAIL rnd_fill_gnt: addr %h cycle %0d count %0d", pool[i], gc, gn);
         end
      end
      for (int n = 0; n < 40; n++) begin
         kind = $urandom_range(0, 3);
         a    = pool[$urandom_range(0, 7)];
         l    = rand_line();
         drop = -1;
         rd   = (kind == 0 || kind == 2);
         wr   = (kind == 1 || kind == 2);
         if (kind == 3) begin
            drop = $urandom_range(1, LAT - 1);
            rd   = $urandom_range(0, 1) == 1;
            wr   = !rd;
         end
         run_req(rd, wr, a, l, drop, gc, gn);
         if (drop < 0) begin
            if (wr) mem_m[int'(a)] = l;
            else    rd_line_m = model_rd(int'(a));
         end
         n_chk++;
         if (gn !== ((drop < 0) ? 1 : 0) || (drop < 0 && gc !== LAT)) begin
            n_fail++; $display("FAIL rnd_gnt[%0d]: kind %0d cycle %0d count %0d", n, kind, gc, gn);
         end
         n_chk++;
         if (rd_line !== rd_line_m) begin
            n_fail++; $display("FAIL rnd_rd_line[%0d]: got %h expected %h", n, rd_line, rd_line_m);
         end
      end
   endtask

`ifdef LINE_MEM_STATS_EN
   task automatic test_stats();
      int gc, gn;
      pulse_reset();
      n_chk++;
      if (rd_cnt !== 32'd0 || wr_cnt !== 32'd0) begin
         n_fail++; $display("FAIL stats_start: rd %0d wr %0d expected 0 0", rd_cnt, wr_cnt);
      end
      for (int i = 0; i < 3; i++) begin
         run_req(1'b0, 1'b1, AL'(i), rand_line(), -1, gc, gn);
      end
      for (int i = 0; i < 2; i++) begin
         run_req(1'b1, 1'b0, AL'(i), rand_line(), -1, gc, gn);
      end
      run_req(1'b1, 1'b0, AL'(2), rand_line(), 2, gc, gn);
      n_chk++;
      if (wr_cnt !== 32'd3 || rd_cnt !== 32'd2) begin
         n_fail++; $display("FAIL stats_count: rd %0d wr %0d expected 2 3", rd_cnt, wr_cnt);
      end
      pulse_reset();
      n_chk++;
      if (rd_cnt !== 32'd0 || wr_cnt !== 32'd0) begin
         n_fail++; $display("FAIL stats_reset: rd %0d wr %0d expected 0 0", rd_cnt, wr_cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_write_read();
      test_back_to_back();
      test_abort();
      test_both();
      test_reset_mid_busy();
      test_random();
`ifdef LINE_MEM_STATS_EN
      test_stats();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
